parity_bit_checker: RTL and testbench
=====================================

// Module: parity_bit_checker
// PURPOSE
//   Registered 4-bit parity checker. Samples data bits a..d plus a received
//   parity bit p and flags a parity error on pec one clock later.
//   Sits at the receive side of a nibble link. Keeps a sticky error flag and
//   an optional saturating error counter for status readout.
// PARAMETERS
//   ODD_PARITY  0  0: even parity (error when XOR of a,b,c,d,p is 1);
//                  1: odd parity (error when that XOR is 0)
//   CNT_W       8  width of err_count, >= 1
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous, active-high reset
//   a,b,c,d     in   1      data bits (a = MSB, d = LSB)
//   p           in   1      received parity bit
//   in_valid    in   1      a,b,c,d,p are sampled this cycle
//   clr         in   1      synchronous clear of err_sticky and err_count
//   pec         out  1      parity error check result, 1 = error
//   out_valid   out  1      pec holds a fresh result
//   err_sticky  out  1      set by any error, held until clr or rst
//   err_count   out  CNT_W  number of errors, saturating
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): pec=0, out_valid=0, err_sticky=0, err_count=0.
//     rst overrides in_valid and clr in the same cycle.
//   - Error term: e = a^b^c^d^p, XORed with ODD_PARITY.
//   - Latency is 1 cycle. If in_valid=1 at edge N, then after edge N:
//     pec=e and out_valid=1.
//   - If in_valid=0 at an edge, then after that edge: out_valid=0 and
//     pec holds its previous value.
//   - Inputs may change every cycle; this gives full throughput with
//     no backpressure.
//   - err_sticky is set after any edge where in_valid=1 and e=1.
//   - err_count increments by 1 on the same condition and saturates
//     at 2^CNT_W-1 (no wrap).
//   - clr=1 forces err_sticky=0 and err_count=0 after the edge.
//   - clr and an error in the same cycle: clr wins for the status outputs
//     (that error is not counted and does not set sticky), but pec still
//     reports it.
//   - Purely synchronous design; no combinational path from any input
//     to any output.
// CONFIGURATION
//   PBC_ERR_COUNT_EN defined: err_count operates as described above.
//   Not defined: the counter logic is removed and err_count is tied to 0;
//     the port stays present. pec, out_valid and err_sticky are unchanged.
// STRUCTURE
//   - Package pbc_pkg holds:
//     - localparam PBC_DATA_W = 4;
//     - typedef logic [PBC_DATA_W-1:0] pbc_nibble_t;
//     - function pbc_parity(nibble, p, odd), returning the error term e.
//   - Sub-module pbc_parity_tree: purely combinational XOR reduction of
//     {a,b,c,d,p} with the odd/even select. The top level registers its
//     output and holds the status logic.
// TESTING
//   - Reset: assert rst 2 cycles with in_valid=1, a..p=1,0,0,0,0
//     -> pec=0, out_valid=0, err_sticky=0, err_count=0.
//   - Exhaustive sweep: ODD_PARITY=0, all 32 {a,b,c,d,p} combinations
//     driven back to back with in_valid=1. pec must equal ^{a,b,c,d,p}
//     one cycle later. Examples: 1010,p=0 -> pec=0; 1110,p=0 -> pec=1.
//     After the sweep, err_count=16 and err_sticky=1.
//   - Odd mode: ODD_PARITY=1, a..d=0000, p=0 -> pec=1; p=1 -> pec=0.
//   - Hold: in_valid=0 after an error -> out_valid=0, pec stays 1,
//     err_count unchanged.
//   - Clear race: clr=1 in the same cycle as an error input
//     -> pec=1, err_sticky=0, err_count=0.
//   - Saturation: CNT_W=2, 5 consecutive errors -> err_count=3.
//     With PBC_ERR_COUNT_EN undefined -> err_count=0 throughout.

Source files
------------

// File: rtl/pbc_pkg.sv
// Shared types and the parity helper for the parity_bit_checker slice.
// Purely declarative; no state and no flow control.
// Default build: no macros needed.
package pbc_pkg;

    localparam int PBC_DATA_W = 4;

    typedef logic [PBC_DATA_W-1:0] pbc_nibble_t;

    // Returns the error term: 1 means the received parity disagrees with the data.
    function automatic logic pbc_parity(input pbc_nibble_t nibble, input logic p, input logic odd);
        return (^nibble) ^ p ^ odd;
    endfunction

endpackage

// File: rtl/pbc_parity_tree.sv
// Combinational XOR reduction of {nibble, p} with odd/even select.
// Latency 0 (pure logic); no flow control, the caller registers the result.
// Default build: no macros needed.
module pbc_parity_tree
    import pbc_pkg::*;
#(
    parameter bit ODD_PARITY = 1'b0
) (
    input  pbc_nibble_t nibble,
    input  logic        p,
    output logic        e
);

    assign e = pbc_parity(nibble, p, ODD_PARITY);

endmodule

// File: rtl/parity_bit_checker.sv
// Registered nibble parity checker with sticky flag and optional error counter (PBC_ERR_COUNT_EN).
// Latency 1 cycle from in_valid to out_valid/pec.
// No backpressure: accepts a new sample every cycle.
module parity_bit_checker
    import pbc_pkg::*;
#(
    parameter bit ODD_PARITY = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             p,
    input  logic             in_valid,
    input  logic             clr,
    output logic             pec,
    output logic             out_valid,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count
);

    pbc_nibble_t nibble;
    logic        e;
    logic        err_hit;

    assign nibble  = {a, b, c, d};
    assign err_hit = in_valid & e;

    pbc_parity_tree #(
        .ODD_PARITY(ODD_PARITY)
    ) u_tree (
        .nibble(nibble),
        .p     (p),
        .e     (e)
    );

    // pec reports every sample, even one whose status update is suppressed by clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            pec        <= 1'b0;
            out_valid  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                pec <= e;
            end
            if (clr) begin
                err_sticky <= 1'b0;
            end else if (err_hit) begin
                err_sticky <= 1'b1;
            end
        end
    end

`ifdef PBC_ERR_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt;

    // Saturates at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (err_hit && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign err_count = cnt;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_parity_bit_checker.sv
// Directed bench for parity_bit_checker: even/odd instances plus a 2-bit counter instance.
module tb_parity_bit_checker;

`ifdef PBC_ERR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, a, b, c, d, p, in_valid, clr;
    logic       pec0, ov0, st0;
    logic       pec1, ov1, st1;
    logic       pec2, ov2, st2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt0;
    int exp_cnt2;
    logic [4:0] vec;

    always #5 clk = ~clk;

    parity_bit_checker #(.ODD_PARITY(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .p(p),
        .in_valid(in_valid), .clr(clr),
        .pec(pec0), .out_valid(ov0), .err_sticky(st0), .err_count(cnt0)
    );

    parity_bit_checker #(.ODD_PARITY(1'b1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .p(p),
        .in_valid(in_valid), .clr(clr),
        .pec(pec1), .out_valid(ov1), .err_sticky(st1), .err_count(cnt1)
    );

    parity_bit_checker #(.ODD_PARITY(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .p(p),
        .in_valid(in_valid), .clr(clr),
        .pec(pec2), .out_valid(ov2), .err_sticky(st2), .err_count(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] v, input logic vld);
        {a, b, c, d, p} = v;
        in_valid = vld;
    endtask

    // Advance one edge, then let outputs settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int cexp(input int v);
        return CNT_EN ? v : 0;
    endfunction

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        drive(5'b10000, 1'b1);

        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst_pec", pec0, 0);
            chk("rst_ov", ov0, 0);
            chk("rst_sticky", st0, 0);
            chk("rst_cnt", cnt0, 0);
            chk("rst_pec_odd", pec1, 0);
        end

        rst = 1'b0;
        exp_cnt0 = 0;
        exp_cnt2 = 0;
        for (int i = 0; i < 32; i++) begin
            vec = i[4:0];
            drive(vec, 1'b1);
            step();
            chk("sweep_pec", pec0, {31'd0, ^vec});
            chk("sweep_ov", ov0, 1);
            chk("sweep_pec_odd", pec1, {31'd0, ~^vec});
            if (^vec) begin
                exp_cnt0++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
            if (i == 20) chk("ex_1010_p0", pec0, 0);
            if (i == 28) chk("ex_1110_p0", pec0, 1);
        end
        chk("sweep_cnt", cnt0, cexp(16));
        chk("sweep_sticky", st0, 1);
        chk("sweep_cnt_sat", cnt2, cexp(exp_cnt2));

        drive(5'b00000, 1'b1);
        step();
        chk("odd_p0", pec1, 1);
        chk("even_p0", pec0, 0);
        drive(5'b00001, 1'b1);
        step();
        chk("odd_p1", pec1, 0);
        exp_cnt0 = 17;

        drive(5'b00001, 1'b1);
        step();
        exp_cnt0 = 18;
        chk("pre_hold_pec", pec0, 1);
        drive(5'b00000, 1'b0);
        step();
        chk("hold_ov", ov0, 0);
        chk("hold_pec", pec0, 1);
        chk("hold_cnt", cnt0, cexp(exp_cnt0));
        step();
        chk("hold2_pec", pec0, 1);
        chk("hold2_cnt", cnt0, cexp(exp_cnt0));

        clr = 1'b1;
        drive(5'b00001, 1'b1);
        step();
        clr = 1'b0;
        chk("clr_pec", pec0, 1);
        chk("clr_sticky", st0, 0);
        chk("clr_cnt", cnt0, 0);
        chk("clr_cnt2", cnt2, 0);

        for (int k = 1; k <= 5; k++) begin
            drive(5'b00001, 1'b1);
            step();
            chk("sat_cnt", cnt2, cexp(k > 3 ? 3 : k));
            chk("sat_sticky", st2, 1);
        end
        chk("sat_cnt_wide", cnt0, cexp(5));

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_sticky", st0, 0);
        chk("rst2_cnt", cnt0, 0);
        chk("rst2_pec", pec0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
